change_dispenser: RTL
=====================

# change_dispenser

Downstream stage of the vending `control` FSM. On each completed or cancelled transaction it takes `sum_money` and `price`, computes the change (or full refund), and pays it out one coin at a time through the `deno_20`/`deno_10`/`deno_5` eject strobes. It tracks a per-denomination coin inventory and picks the largest coin that fits and is in stock. Each eject is handshaked with the coin mechanism.

## Interface
- `CNT_W`, 6: width of each coin-tube counter.
- `INIT_CNT`, 20: coins per tube after reset and after `reload`.
- `clk` input 1: single clock, all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset. Deassertion is synchronous to `clk`.
- `end_trans` input 1: one-cycle strobe from `control` marking the end of a transaction.
- `done` input 1: qualifies `end_trans`. 1 = purchase completed; 0 = cancel/refund.
- `sum_money` input 8: total money inserted, unsigned.
- `price` input 8: price of the selected item, unsigned.
- `coin_ack` input 1: mechanism acknowledges that the ejected coin has been released.
- `reload` input 1: refill all tubes to `INIT_CNT`. Honoured only in IDLE.
- `deno_20`, `deno_10`, `deno_5` output 1 each: one-hot eject request, held until `coin_ack`.
- `busy` output 1: high in any state other than IDLE.
- `change_done` output 1: one-cycle pulse when payout finishes.
- `short_change` output 1: registered with `change_done`. Set if any change could not be paid. Held until the next `end_trans`.
- `short_amt` output 8: amount left unpaid. Valid while `short_change` is high.
- `underpay` output 1: one-cycle pulse when `done=1` and `sum_money < price`.
- `cnt_20`, `cnt_10`, `cnt_5` output `CNT_W` each: current tube inventory.

## Operation
- States: IDLE, CALC, PICK, EJECT, FINISH.
- IDLE, `end_trans=1`:
  - go to CALC;
  - latch `rem = done ? sum_money - price : sum_money`;
  - clear `short_change` and `short_amt`.
- Underpay: if `done=1` and `sum_money < price`, then `rem = 0` and `underpay` pulses in CALC.
- CALC → PICK, unconditionally.
- PICK, greedy on inventory:
  - if `rem >= 20` and `cnt_20 > 0`, select 20; else if `rem >= 10` and `cnt_10 > 0`, select 10; else if `rem >= 5` and `cnt_5 > 0`, select 5;
  - a selection asserts the matching `deno_*` and moves to EJECT;
  - no selection moves to FINISH.
- EJECT: hold the strobe. On `coin_ack`:
  - drop the strobe;
  - `rem -= coin`;
  - decrement that tube;
  - return to PICK.
- FINISH: pulse `change_done`, set `short_change = (rem != 0)` and `short_amt = rem`, return to IDLE.
- Ignored inputs:
  - `end_trans` outside IDLE;
  - `coin_ack` outside EJECT;
  - `reload` outside IDLE.
- A remainder that is not a multiple of 5 (e.g. 7) pays what it can and reports the rest as short.
- Tube counters never underflow: an empty tube is never selected.
- `reload` and `end_trans` in the same IDLE cycle: both take effect. The refill is visible from CALC onward.

## Timing
- Reset values:
  - state IDLE;
  - all `deno_*`, `busy`, `change_done`, `short_change`, `underpay` = 0;
  - `short_amt` = 0;
  - `cnt_*` = `INIT_CNT`;
  - `rem` = 0.
- Reset mid-payout: the strobe drops immediately (asynchronous), inventory returns to `INIT_CNT`, the pending change is discarded.
- Latencies:
  - `end_trans` at edge N: `busy` high after N;
  - first `deno_*` high after edge N+2;
  - `coin_ack` at edge M: strobe low after M, next strobe after M+1;
  - each coin costs at least 2 cycles;
  - zero change: `change_done` after edge N+3.
- `coin_ack` may be held high. Each PICK→EJECT entry consumes one ack edge.
- Arithmetic is 8-bit unsigned. The underpay compare happens before the subtract, so the subtract never wraps.

## Structure
- `vending_pkg` contains:
  - `deno_e` enum;
  - constants `COIN_20 = 20`, `COIN_10 = 10`, `COIN_5 = 5`;
  - `chg_state_e` enum {IDLE, CALC, PICK, EJECT, FINISH};
  - the `control` state encodings, shared with the existing FSM.
- Sub-module `coin_tube`, instantiated three times:
  - `CNT_W` counter with reload-to-`INIT_CNT`, decrement, and a `nonempty` flag;
  - asynchronous active-low reset.

## Test plan
- Reset, then `done=1`, `sum_money=50`, `price=15` → strobes 20, 10, 5 in order; `change_done` with `short_change=0`; counts 19/19/19.
- Cancel refund, `done=0`, `sum_money=30` → strobes 20, 10; `change_done`; `price` ignored.
- Tube 20 drained to 0 → `sum=45`, `price=5` yields four 10s; `short_change=0`.
- `sum=22`, `price=15` → one 5 paid; `short_change=1`, `short_amt=2`.
- `sum=10`, `price=15`, `done=1` → `underpay` pulse; no strobes; `change_done` 3 cycles after `end_trans`.
- `reset_n` low while `deno_20` is waiting for `coin_ack` → strobe low immediately; state IDLE; counts back to 20; a later `coin_ack` has no effect.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending-machine types: coin denominations, change-dispenser states and
// the control FSM encodings.
package vending_pkg;

   localparam logic [7:0] COIN_20 = 8'd20;
   localparam logic [7:0] COIN_10 = 8'd10;
   localparam logic [7:0] COIN_5  = 8'd5;

   typedef enum logic [1:0] {
      DENO_5,
      DENO_10,
      DENO_20
   } deno_e;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      PICK,
      EJECT,
      FINISH
   } chg_state_e;

   // Encodings of the upstream control FSM; kept here so both sides agree.
   typedef enum logic [2:0] {
      CTRL_IDLE,
      CTRL_COLLECT,
      CTRL_SELECT,
      CTRL_VEND,
      CTRL_REFUND
   } ctrl_state_e;

   function automatic logic [7:0] coin_value(deno_e d);
      logic [7:0] v;
      unique case (d)
         DENO_20: v = COIN_20;
         DENO_10: v = COIN_10;
         default: v = COIN_5;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/coin_tube.sv
// Inventory counter for one coin tube: reload to a full tube, decrement per
// ejected coin, and report whether any coin is left.
module coin_tube #(
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned INIT_CNT = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             reload_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nonempty_o
);

   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(INIT_CNT);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (reload_i) begin
         cnt_d = FullCnt;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= FullCnt;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign nonempty_o = (cnt_q != '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out change or a refund one coin at a time, largest in-stock coin first,
// handshaking each eject with the coin mechanism.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned INIT_CNT = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             end_trans,
   input  logic             done,
   input  logic [7:0]       sum_money,
   input  logic [7:0]       price,
   input  logic             coin_ack,
   input  logic             reload,
   output logic             deno_20,
   output logic             deno_10,
   output logic             deno_5,
   output logic             busy,
   output logic             change_done,
   output logic             short_change,
   output logic [7:0]       short_amt,
   output logic             underpay,
   output logic [CNT_W-1:0] cnt_20,
   output logic [CNT_W-1:0] cnt_10,
   output logic [CNT_W-1:0] cnt_5
);

   chg_state_e state_d, state_q;
   deno_e      sel_d, sel_q;
   logic [7:0] rem_d, rem_q;
   logic [2:0] deno_d, deno_q;  // {20, 10, 5}
   logic       busy_d, busy_q;
   logic       change_done_d, change_done_q;
   logic       short_change_d, short_change_q;
   logic [7:0] short_amt_d, short_amt_q;
   logic       underpay_d, underpay_q;

   logic       reload_en;
   logic       ack_en;
   logic       ne_20, ne_10, ne_5;

   assign reload_en = (state_q == IDLE) && reload;
   assign ack_en    = (state_q == EJECT) && coin_ack;

   coin_tube #(.CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) u_tube_20 (
      .clk       (clk),
      .reset_n   (reset_n),
      .reload_i  (reload_en),
      .dec_i     (ack_en && (sel_q == DENO_20)),
      .cnt_o     (cnt_20),
      .nonempty_o(ne_20)
   );

   coin_tube #(.CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) u_tube_10 (
      .clk       (clk),
      .reset_n   (reset_n),
      .reload_i  (reload_en),
      .dec_i     (ack_en && (sel_q == DENO_10)),
      .cnt_o     (cnt_10),
      .nonempty_o(ne_10)
   );

   coin_tube #(.CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) u_tube_5 (
      .clk       (clk),
      .reset_n   (reset_n),
      .reload_i  (reload_en),
      .dec_i     (ack_en && (sel_q == DENO_5)),
      .cnt_o     (cnt_5),
      .nonempty_o(ne_5)
   );

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      rem_d          = rem_q;
      deno_d         = deno_q;
      change_done_d  = 1'b0;
      underpay_d     = 1'b0;
      short_change_d = short_change_q;
      short_amt_d    = short_amt_q;

      unique case (state_q)
         IDLE: begin
            if (end_trans) begin
               state_d        = CALC;
               short_change_d = 1'b0;
               short_amt_d    = '0;
               // Compare before subtracting so an underpay never wraps.
               if (done) begin
                  underpay_d = (sum_money < price);
                  rem_d      = (sum_money < price) ? 8'd0 : sum_money - price;
               end else begin
                  rem_d = sum_money;
               end
            end
         end
         CALC: state_d = PICK;
         PICK: begin
            if ((rem_q >= COIN_20) && ne_20) begin
               sel_d   = DENO_20;
               deno_d  = 3'b100;
               state_d = EJECT;
            end else if ((rem_q >= COIN_10) && ne_10) begin
               sel_d   = DENO_10;
               deno_d  = 3'b010;
               state_d = EJECT;
            end else if ((rem_q >= COIN_5) && ne_5) begin
               sel_d   = DENO_5;
               deno_d  = 3'b001;
               state_d = EJECT;
            end else begin
               state_d = FINISH;
            end
         end
         EJECT: begin
            if (coin_ack) begin
               deno_d  = 3'b000;
               rem_d   = rem_q - coin_value(sel_q);
               state_d = PICK;
            end
         end
         FINISH: begin
            change_done_d  = 1'b1;
            short_change_d = (rem_q != 8'd0);
            short_amt_d    = rem_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         sel_q          <= DENO_5;
         rem_q          <= '0;
         deno_q         <= '0;
         busy_q         <= 1'b0;
         change_done_q  <= 1'b0;
         short_change_q <= 1'b0;
         short_amt_q    <= '0;
         underpay_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         rem_q          <= rem_d;
         deno_q         <= deno_d;
         busy_q         <= busy_d;
         change_done_q  <= change_done_d;
         short_change_q <= short_change_d;
         short_amt_q    <= short_amt_d;
         underpay_q     <= underpay_d;
      end
   end

   assign deno_20      = deno_q[2];
   assign deno_10      = deno_q[1];
   assign deno_5       = deno_q[0];
   assign busy         = busy_q;
   assign change_done  = change_done_q;
   assign short_change = short_change_q;
   assign short_amt    = short_amt_q;
   assign underpay     = underpay_q;

endmodule
